// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the core's single data-memory port.
// Parks on the current owner for bounded bursts and returns registered read data.
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);
  localparam logic [CW-1:0] OneCnt = CW'(1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          burst_open;
  logic          gnt0, gnt1;
  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  // Grant decision; reset masks grants immediately, even mid-cycle.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    burst_open = (burst_cnt_q < MaxCnt);
    case (owner_q)
      StOwn0: begin
        if (m0_req && (!m1_req || burst_open)) gnt0 = 1'b1;
        else if (m1_req)                       gnt1 = 1'b1;
      end
      StOwn1: begin
        if (m1_req && (!m0_req || burst_open)) gnt1 = 1'b1;
        else if (m0_req)                       gnt0 = 1'b1;
      end
      default: begin
        if (m0_req)      gnt0 = 1'b1;
        else if (m1_req) gnt1 = 1'b1;
      end
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    owner_d     = StIdle;
    burst_cnt_d = '0;
    cnt_inc     = (burst_cnt_q == MaxCnt) ? burst_cnt_q : burst_cnt_q + OneCnt;
    if (gnt0) begin
      owner_d     = StOwn0;
      burst_cnt_d = (owner_q == StOwn0) ? cnt_inc : OneCnt;
    end else if (gnt1) begin
      owner_d     = StOwn1;
      burst_cnt_d = (owner_q == StOwn1) ? cnt_inc : OneCnt;
    end
  end

  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    if (gnt0) begin
      mem_a  = m0_addr;
      mem_wd = m0_wdata;
    end else if (gnt1) begin
      mem_a  = m1_addr;
      mem_wd = m1_wdata;
    end
    mem_we = (gnt0 & m0_we) | (gnt1 & m1_we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= StIdle;
      burst_cnt_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      m0_rvalid_q <= gnt0 & ~m0_we;
      m1_rvalid_q <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata_q <= mem_rd;
      if (gnt1 && !m1_we) m1_rdata_q <= mem_rd;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a MAX_BURST=4 instance plus a MAX_BURST=1
// instance sharing the same stimulus.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rd;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_a, b_mem_wd;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_a(b_mem_a), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp0;
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h55;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0;
    mem_rd = 32'h0;

    // Reset state, with a request pending that must not be granted
    #2;
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_burst_cnt", 32'(dut.burst_cnt_q), 32'd0);

    // Lone port-1 read
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; mem_rd = 32'hDEADBEEF;
    #1;
    chk1("rd1_m1_gnt", m1_gnt, 1'b1);
    chk1("rd1_m0_gnt", m0_gnt, 1'b0);
    chk("rd1_mem_a", mem_a, 32'h10);
    chk1("rd1_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    chk1("rd1_m1_rvalid", m1_rvalid, 1'b1);
    chk("rd1_m1_rdata", m1_rdata, 32'hDEADBEEF);
    chk1("rd1_m0_rvalid", m0_rvalid, 1'b0);
    chk("rd1_burst_cnt", 32'(dut.burst_cnt_q), 32'd1);
    @(negedge clk);
    m1_req = 1'b0; mem_rd = 32'h0;
    #1;
    chk1("rd1_idle_m1_gnt", m1_gnt, 1'b0);
    @(posedge clk); #1;
    chk1("rd1_rvalid_drop", m1_rvalid, 1'b0);
    chk("rd1_rdata_hold", m1_rdata, 32'hDEADBEEF);
    chk1("rd1_m0_rvalid_2", m0_rvalid, 1'b0);

    // Tie from IDLE: port-0 write wins
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h12345678;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
    #1;
    chk1("tie_m0_gnt", m0_gnt, 1'b1);
    chk1("tie_m1_gnt", m1_gnt, 1'b0);
    chk1("tie_mem_we", mem_we, 1'b1);
    chk("tie_mem_a", mem_a, 32'h20);
    chk("tie_mem_wd", mem_wd, 32'h12345678);
    @(posedge clk); #1;
    chk1("tie_no_rvalid", m0_rvalid, 1'b0);

    // One idle cycle, then 12 cycles of contention with reads
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h24;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m1_req = 1'b1;
      mem_rd = 32'h1000 + 32'(i);
      exp0 = ((i / 4) % 2) == 0;
      #1;
      chk1($sformatf("cont%0d_m0_gnt", i), m0_gnt, exp0);
      chk1($sformatf("cont%0d_m1_gnt", i), m1_gnt, !exp0);
      chk1($sformatf("alt%0d_m0_gnt", i), b_m0_gnt, (i % 2) == 0);
      chk1($sformatf("alt%0d_m1_gnt", i), b_m1_gnt, (i % 2) == 1);
      @(posedge clk); #1;
      chk1($sformatf("cont%0d_m0_rvalid", i), m0_rvalid, exp0);
      chk1($sformatf("cont%0d_m1_rvalid", i), m1_rvalid, !exp0);
      if (exp0) chk($sformatf("cont%0d_m0_rdata", i), m0_rdata, 32'h1000 + 32'(i));
      else      chk($sformatf("cont%0d_m1_rdata", i), m1_rdata, 32'h1000 + 32'(i));
    end

    // Port 1 takes over, reaches burst_cnt=2, then hands off in the same cycle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b1;
      #1;
      chk1($sformatf("own1_%0d_m1_gnt", i), m1_gnt, 1'b1);
      @(posedge clk); #1;
    end
    chk("own1_burst_cnt", 32'(dut.burst_cnt_q), 32'd2);
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0;
    #1;
    chk1("handoff_m0_gnt", m0_gnt, 1'b1);
    chk1("handoff_m1_gnt", m1_gnt, 1'b0);
    @(posedge clk); #1;
    chk("handoff_burst_cnt", 32'(dut.burst_cnt_q), 32'd1);

    // Asynchronous reset in the middle of a port-0 read grant
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; mem_rd = 32'hCAFEF00D;
    #1;
    chk1("arst_pre_m0_gnt", m0_gnt, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_m0_gnt", m0_gnt, 1'b0);
    chk1("arst_mem_we", mem_we, 1'b0);
    chk("arst_mem_a", mem_a, 32'h0);
    @(posedge clk); #1;
    chk1("arst_no_rvalid", m0_rvalid, 1'b0);
    chk("arst_m0_rdata", m0_rdata, 32'h0);
    chk("arst_burst_cnt", 32'(dut.burst_cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h50; mem_rd = 32'h0BADCAFE;
    #1;
    chk1("post_m0_gnt", m0_gnt, 1'b1);
    chk1("post_m1_gnt", m1_gnt, 1'b0);
    @(posedge clk); #1;
    chk1("post_m0_rvalid", m0_rvalid, 1'b1);
    chk("post_m0_rdata", m0_rdata, 32'h0BADCAFE);
    chk("post_burst_cnt", 32'(dut.burst_cnt_q), 32'd1);

    // Five cycles without requests
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1($sformatf("idle%0d_mem_we", i), mem_we, 1'b0);
      chk($sformatf("idle%0d_mem_a", i), mem_a, 32'h0);
      chk1($sformatf("idle%0d_m0_gnt", i), m0_gnt, 1'b0);
      chk1($sformatf("idle%0d_m1_gnt", i), m1_gnt, 1'b0);
      @(negedge clk);
    end

    // Lone port-1 write, then a long port-1 run to show saturation
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h60; m1_wdata = 32'hA5A5A5A5;
    #1;
    chk1("lone_m1_gnt", m1_gnt, 1'b1);
    chk1("lone_mem_we", mem_we, 1'b1);
    chk("lone_mem_wd", mem_wd, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("lone_burst_cnt", 32'(dut.burst_cnt_q), 32'd1);
    chk1("lone_no_rvalid", m1_rvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m1_we = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("sat%0d_burst_cnt", i), 32'(dut.burst_cnt_q), (i + 2 > 4) ? 32'd4 : 32'(i + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
